// File: rtl/register_file_8x8.sv
// Eight-entry, 8-bit register file: one synchronous write port and two
// combinational read ports, each read port built from an 8:1 byte mux.

module eight_bit_8_1_mux (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_c,
    input  logic [7:0] i_d,
    input  logic [7:0] i_e,
    input  logic [7:0] i_f,
    input  logic [7:0] i_g,
    input  logic [7:0] i_h,
    input  logic       i_s0,
    input  logic       i_s1,
    input  logic       i_s2,
    output logic [7:0] o_y
);

    logic [7:0] w_low;
    logic [7:0] w_high;

    // First level: two 4:1 muxes on {s1,s0}; second level: 2:1 on s2.
    // NOTE: every branch of a case in always_comb assigns the output (with a
    // default first), otherwise synthesis infers a latch.
    always_comb begin
        w_low = i_a;
        unique case ({i_s1, i_s0})
            2'b00:   w_low = i_a;
            2'b01:   w_low = i_b;
            2'b10:   w_low = i_c;
            default: w_low = i_d;
        endcase
    end

    always_comb begin
        w_high = i_e;
        unique case ({i_s1, i_s0})
            2'b00:   w_high = i_e;
            2'b01:   w_high = i_f;
            2'b10:   w_high = i_g;
            default: w_high = i_h;
        endcase
    end

    assign o_y = i_s2 ? w_high : w_low;

endmodule

module register_file_8x8 #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter bit         ZERO_REG    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr_a,
    input  logic [2:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b
);

    logic [7:0] r_regs [8];
    logic [7:0] w_load_en;

    // One-hot (or all-zero) load enables; reg0 never loads when hardwired.
    always_comb begin
        w_load_en = 8'h00;
        if (we) begin
            w_load_en = 8'h01 << waddr;
        end
        if (ZERO_REG) begin
            w_load_en[0] = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= (ZERO_REG && i == 0) ? 8'h00 : RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_load_en[i]) begin
                    r_regs[i] <= wdata;
                end
            end
        end
    end

    eight_bit_8_1_mux u_mux_a (
        .i_a  (r_regs[0]),
        .i_b  (r_regs[1]),
        .i_c  (r_regs[2]),
        .i_d  (r_regs[3]),
        .i_e  (r_regs[4]),
        .i_f  (r_regs[5]),
        .i_g  (r_regs[6]),
        .i_h  (r_regs[7]),
        .i_s0 (raddr_a[0]),
        .i_s1 (raddr_a[1]),
        .i_s2 (raddr_a[2]),
        .o_y  (rdata_a)
    );

    eight_bit_8_1_mux u_mux_b (
        .i_a  (r_regs[0]),
        .i_b  (r_regs[1]),
        .i_c  (r_regs[2]),
        .i_d  (r_regs[3]),
        .i_e  (r_regs[4]),
        .i_f  (r_regs[5]),
        .i_g  (r_regs[6]),
        .i_h  (r_regs[7]),
        .i_s0 (raddr_b[0]),
        .i_s1 (raddr_b[1]),
        .i_s2 (raddr_b[2]),
        .o_y  (rdata_b)
    );

endmodule

// File: tb/tb_register_file_8x8.sv
// Directed bench for register_file_8x8: three instances (default, ZERO_REG=1,
// RESET_VALUE=8'h5A) share one stimulus stream and a small expected-value table.

module tb_register_file_8x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] ra [3];
    logic [7:0] rb [3];

    logic [7:0] exp_regs [3][8];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    register_file_8x8 #(.RESET_VALUE(8'h00), .ZERO_REG(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[0]), .rdata_b(rb[0])
    );
    register_file_8x8 #(.RESET_VALUE(8'h00), .ZERO_REG(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[1]), .rdata_b(rb[1])
    );
    register_file_8x8 #(.RESET_VALUE(8'h5A), .ZERO_REG(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra[2]), .rdata_b(rb[2])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            exp_regs[0][i] = 8'h00;
            exp_regs[1][i] = 8'h00;
            exp_regs[2][i] = 8'h5A;
        end
    endtask

    task automatic model_write(input logic [2:0] a, input logic [7:0] d);
        exp_regs[0][a] = d;
        if (a != 3'd0) exp_regs[1][a] = d;
        exp_regs[2][a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
        model_write(a, d);
    endtask

    // Port A sweeps 0..7 while port B sweeps 7..0 on every instance.
    task automatic check_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s dut%0d A@%0d", tag, k, a), ra[k], exp_regs[k][a]);
                check($sformatf("%s dut%0d B@%0d", tag, k, 7 - a), rb[k], exp_regs[k][7 - a]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

        // Reset state
        do_reset();
        check_all("reset");

        // Write/readback
        for (int n = 0; n < 8; n++) do_write(3'(n), 8'h10 + 8'(n));
        check_all("wr");
        raddr_a = 3'd3; #1;
        check("wr const dut0 A@3", ra[0], 8'h13);
        raddr_a = 3'd0; raddr_b = 3'd0; #1;
        check("zero dut1 A@0 after 10", ra[1], 8'h00);
        check("dut2 A@0 after 10", ra[2], 8'h10);

        // Same-cycle write/read: old value before edge, new one after
        raddr_a = 3'd3;
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        #1;
        check("bypass old dut0", ra[0], 8'h13);
        tick();
        check("bypass new dut0", ra[0], 8'hA5);
        model_write(3'd3, 8'hA5);
        we = 1'b0; wdata = 8'hFF;
        tick();
        check("we0 hold dut0", ra[0], 8'hA5);
        check_all("we0");

        // Reset beats a concurrent write
        rst = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'h77; raddr_a = 3'd5;
        tick();
        model_reset();
        check("rstprio dut0", ra[0], 8'h00);
        check("rstprio dut2", ra[2], 8'h5A);
        rst = 1'b0;
        tick();
        we = 1'b0;
        model_write(3'd5, 8'h77);
        check("after rst dut0", ra[0], 8'h77);
        check("after rst dut2", ra[2], 8'h77);

        // Hardwired reg0
        do_write(3'd0, 8'hFF);
        do_write(3'd1, 8'h3C);
        raddr_a = 3'd0; raddr_b = 3'd0; #1;
        check("zero dut1 A@0", ra[1], 8'h00);
        check("zero dut1 B@0", rb[1], 8'h00);
        check("nozero dut0 A@0", ra[0], 8'hFF);
        raddr_a = 3'd1; #1;
        check("zero dut1 A@1", ra[1], 8'h3C);

        // Back-to-back writes to one address
        raddr_b = 3'd2;
        we = 1'b1; waddr = 3'd2; wdata = 8'h11;
        tick();
        check("b2b first dut0", rb[0], 8'h11);
        wdata = 8'h22;
        tick();
        we = 1'b0;
        check("b2b last dut0", rb[0], 8'h22);
        model_write(3'd2, 8'h22);
        check_all("b2b");

        // Nonzero reset value, reset mid-sequence
        do_write(3'd7, 8'h01);
        raddr_a = 3'd7; #1;
        check("rv dut2 A@7 pre", ra[2], 8'h01);
        rst = 1'b1; we = 1'b1; waddr = 3'd7; wdata = 8'h99;
        tick();
        rst = 1'b0; we = 1'b0;
        model_reset();
        check("rv dut2 A@7 post", ra[2], 8'h5A);
        check_all("rv");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
